uart_tx_core: RTL and testbench

//  UART transmitter, the send side of the uartRx_top receiver; same frame format and config ports.

---
 rtl/uart_tx_core.sv | 177 +++++++++++++++++
 tb/tb_uart_tx_core.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx_core.sv
// uart_tx_core
//   UART transmitter. A word handed in on p_data is sent on tx_out as one
//   frame: a start bit (0), then dataWidth data bits LSB first, then an
//   optional parity bit, then a stop bit (1). Every bit lasts P clk cycles,
//   where P = prescale, and prescale == 0 means 64.
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous, active-high reset
//   p_data      word to transmit
//   data_valid  transmit request; taken in IDLE or in the last stop cycle
//   par_en      1: append a parity bit
//   par_type    0: even parity, 1: odd parity
//   prescale    clk cycles per bit (0 -> 64)
//   tx_out      serial line, idle high (registered)
//   busy        a frame is on the line (registered)
//   frame_done  one-cycle pulse in the cycle after a stop bit ends
module uart_tx_core #(
  parameter int dataWidth = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [dataWidth-1:0] p_data,
  input  logic                 data_valid,
  input  logic                 par_en,
  input  logic                 par_type,
  input  logic [5:0]           prescale,
  output logic                 tx_out,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int CW = (dataWidth > 1) ? $clog2(dataWidth) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state_reg, state_next;
  logic [5:0]           presc_cnt_reg, presc_cnt_next;
  logic [5:0]           period_m1_reg, period_m1_next;
  logic [CW-1:0]        bit_cnt_reg, bit_cnt_next;
  logic [dataWidth-1:0] shift_reg, shift_next;
  logic                 par_en_reg, par_en_next;
  logic                 par_bit_reg, par_bit_next;
  logic                 tx_out_reg, tx_out_next;
  logic                 busy_reg, busy_next;
  logic                 frame_done_reg, frame_done_next;

  logic                 end_bit;
  logic                 accept;
  logic [dataWidth-1:0] shifted;
  logic [dataWidth:0]   par_chain;

  // Running XOR over the incoming word; the result is captured at accept
  // so the parity bit always belongs to the latched word.
  assign par_chain[0] = 1'b0;
  for (genvar gi = 0; gi < dataWidth; gi++) begin : g_par
    assign par_chain[gi+1] = par_chain[gi] ^ p_data[gi];
  end

  // period_m1 holds P-1; prescale 0 wraps to 63, giving P = 64 for free.
  assign end_bit = (presc_cnt_reg == period_m1_reg);
  assign shifted = shift_reg >> 1;
  // Accepting in the final stop cycle lets the next start bit follow the
  // stop bit with no idle gap.
  assign accept  = data_valid &&
                   ((state_reg == IDLE) || ((state_reg == STOP) && end_bit));

  always_comb begin
    state_next      = state_reg;
    presc_cnt_next  = presc_cnt_reg;
    period_m1_next  = period_m1_reg;
    bit_cnt_next    = bit_cnt_reg;
    shift_next      = shift_reg;
    par_en_next     = par_en_reg;
    par_bit_next    = par_bit_reg;
    tx_out_next     = tx_out_reg;
    busy_next       = busy_reg;
    frame_done_next = 1'b0;

    if (state_reg != IDLE) begin
      presc_cnt_next = end_bit ? 6'd0 : presc_cnt_reg + 6'd1;
    end

    case (state_reg)
      IDLE: begin
        tx_out_next = 1'b1;
        busy_next   = 1'b0;
      end
      START: begin
        if (end_bit) begin
          state_next  = DATA;
          tx_out_next = shift_reg[0];
        end
      end
      DATA: begin
        if (end_bit) begin
          if (bit_cnt_reg == CW'(dataWidth - 1)) begin
            if (par_en_reg) begin
              state_next  = PARITY;
              tx_out_next = par_bit_reg;
            end else begin
              state_next  = STOP;
              tx_out_next = 1'b1;
            end
          end else begin
            bit_cnt_next = bit_cnt_reg + 1'b1;
            shift_next   = shifted;
            tx_out_next  = shifted[0];
          end
        end
      end
      PARITY: begin
        if (end_bit) begin
          state_next  = STOP;
          tx_out_next = 1'b1;
        end
      end
      STOP: begin
        if (end_bit) begin
          state_next      = IDLE;
          tx_out_next     = 1'b1;
          busy_next       = 1'b0;
          frame_done_next = 1'b1;
        end
      end
      default: begin
        state_next  = IDLE;
        tx_out_next = 1'b1;
        busy_next   = 1'b0;
      end
    endcase

    // A new frame overrides whatever the current state decided.
    if (accept) begin
      state_next     = START;
      presc_cnt_next = 6'd0;
      period_m1_next = prescale - 6'd1;
      bit_cnt_next   = '0;
      shift_next     = p_data;
      par_en_next    = par_en;
      par_bit_next   = par_chain[dataWidth] ^ par_type;
      tx_out_next    = 1'b0;
      busy_next      = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      presc_cnt_reg  <= 6'd0;
      period_m1_reg  <= 6'd0;
      bit_cnt_reg    <= '0;
      shift_reg      <= '0;
      par_en_reg     <= 1'b0;
      par_bit_reg    <= 1'b0;
      tx_out_reg     <= 1'b1;
      busy_reg       <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      presc_cnt_reg  <= presc_cnt_next;
      period_m1_reg  <= period_m1_next;
      bit_cnt_reg    <= bit_cnt_next;
      shift_reg      <= shift_next;
      par_en_reg     <= par_en_next;
      par_bit_reg    <= par_bit_next;
      tx_out_reg     <= tx_out_next;
      busy_reg       <= busy_next;
      frame_done_reg <= frame_done_next;
    end
  end

  assign tx_out     = tx_out_reg;
  assign busy       = busy_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_uart_tx_core.sv
// tb_uart_tx_core
//   Drives frames into uart_tx_core and checks tx_out, busy and frame_done
//   in every cycle against a reference frame built from the word and config.
module tb_uart_tx_core;

  logic       clk;
  logic       rst;
  logic [7:0] p_data;
  logic       data_valid;
  logic       par_en;
  logic       par_type;
  logic [5:0] prescale;
  logic       tx_out;
  logic       busy;
  logic       frame_done;

  int tests_run    = 0;
  int tests_failed = 0;

  uart_tx_core #(.dataWidth(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .p_data     (p_data),
    .data_valid (data_valid),
    .par_en     (par_en),
    .par_type   (par_type),
    .prescale   (prescale),
    .tx_out     (tx_out),
    .busy       (busy),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Line level of bit slot idx of a frame: 0 start, 1..8 data LSB first,
  // 9 parity when enabled, then stop.
  function automatic logic ref_line(input logic [7:0] d, input bit pe, input bit pt, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    if (idx == 9 && pe) return logic'(($countones(d) % 2) != 0) ^ pt;
    return 1'b1;
  endfunction

  // Called in a slot where the DUT will accept at the next edge. Returns in
  // the slot of the last stop cycle, with data_valid low.
  task automatic send(input logic [7:0] d, input logic [5:0] ps, input bit pe,
                      input bit pt, input bit noise, input bit fd0);
    int p;
    int total;
    p     = (ps == 6'd0) ? 64 : int'(ps);
    total = (10 + int'(pe)) * p;
    p_data     = d;
    prescale   = ps;
    par_en     = pe;
    par_type   = pt;
    data_valid = 1'b1;
    for (int j = 0; j < total; j++) begin
      @(posedge clk); #1;
      data_valid = 1'b0;
      if (noise && j < total - 1) begin
        data_valid = 1'($urandom_range(0, 1));
        p_data     = 8'($urandom);
        par_en     = 1'($urandom);
        par_type   = 1'($urandom);
        prescale   = 6'($urandom);
      end
      check("tx_out", tx_out, ref_line(d, pe, pt, j / p));
      check("busy", busy, 1);
      check("frame_done", frame_done, (j == 0) ? fd0 : 1'b0);
    end
    $display("[TB] frame d=%02h P=%0d par_en=%0d par_type=%0d noise=%0d cycles=%0d",
             d, p, pe, pt, noise, total);
  endtask

  task automatic end_idle();
    @(posedge clk); #1;
    check("idle_tx", tx_out, 1);
    check("idle_busy", busy, 0);
    check("done_pulse", frame_done, 1);
  endtask

  initial begin
    bit         fd0;
    logic [7:0] d;
    logic [5:0] ps;

    rst        = 1'b1;
    data_valid = 1'b0;
    p_data     = 8'h00;
    par_en     = 1'b0;
    par_type   = 1'b0;
    prescale   = 6'd8;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", tx_out, 1);
    check("rst_busy", busy, 0);
    check("rst_done", frame_done, 0);
    @(negedge clk) rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check("idle_tx", tx_out, 1);
      check("idle_busy", busy, 0);
      check("idle_done", frame_done, 0);
    end

    // Directed frames
    send(8'hA5, 6'd8, 1, 0, 0, 0);  end_idle();
    send(8'hA5, 6'd8, 1, 1, 0, 0);  end_idle();
    send(8'h3C, 6'd16, 0, 0, 0, 0); end_idle();
    send(8'h00, 6'd4, 0, 0, 0, 0);
    send(8'hFF, 6'd4, 0, 0, 0, 1);  end_idle();
    send(8'h55, 6'd8, 0, 0, 1, 0);  end_idle();
    @(posedge clk); #1;
    check("no_queue_busy", busy, 0);
    send(8'hC3, 6'd1, 1, 1, 0, 0);  end_idle();
    send(8'h5A, 6'd0, 1, 0, 0, 0);  end_idle();

    // Reset during data bit 3 of a 0x55 frame, P=8
    p_data = 8'h55; prescale = 6'd8; par_en = 1'b0; par_type = 1'b0;
    data_valid = 1'b1;
    @(posedge clk); #1;
    data_valid = 1'b0;
    repeat (36) @(posedge clk);
    #1;
    check("pre_abort_tx", tx_out, 0);
    rst = 1'b1;
    #1;
    check("abort_tx", tx_out, 1);
    check("abort_busy", busy, 0);
    check("abort_done", frame_done, 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check("post_abort_busy", busy, 0);
    check("post_abort_done", frame_done, 0);
    send(8'h81, 6'd8, 1, 0, 0, 0);  end_idle();

    // data_valid together with reset: nothing accepted
    rst = 1'b1; data_valid = 1'b1; p_data = 8'hAA;
    repeat (3) begin
      @(posedge clk); #1;
      check("rst_dv_busy", busy, 0);
      check("rst_dv_tx", tx_out, 1);
    end
    data_valid = 1'b0;
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check("rst_dv_after", busy, 0);
    $display("[TB] reset/data_valid collision checked");

    // Randomized frames, some chained back-to-back, some with input noise
    fd0 = 1'b0;
    for (int i = 0; i < 40; i++) begin
      d  = 8'($urandom);
      ps = ($urandom_range(0, 9) == 0) ? 6'd0 : 6'($urandom_range(1, 40));
      send(d, ps, 1'($urandom), 1'($urandom), 1'($urandom), fd0);
      if ($urandom_range(0, 2) == 0) begin
        fd0 = 1'b1;
      end else begin
        end_idle();
        fd0 = 1'b0;
      end
    end
    if (fd0) end_idle();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
